// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the uart_tx round-robin scheduler.
// Optional ID-prefix frames are enabled with `define UART_SCHED_ID_EN.
package uart_sched_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_ID    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_ISSUE = ST_ISSUE,
      S_WAIT  = ST_WAIT,
      S_ID    = ST_ID
   } sched_state_t;

   localparam logic [7:0] SCHED_ID_BASE = 8'hA0;

   // Ceiling log2, never below 1 so a bus is always at least one bit wide.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search upward from last+1 with wrap-around.
// Unaffected by UART_SCHED_ID_EN.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int            s;
   logic [IW-1:0] k;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      s   = 0;
      k   = '0;
      for (int i = 1; i <= N; i++) begin
         s = int'(last) + i;
         if (s >= N) s = s - N;
         k = IW'(s);
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte requesters,
// with a done-tick watchdog. `define UART_SCHED_ID_EN prefixes each grant with an ID frame.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_BITS   = 8,
   parameter int TIMEOUT_CYC = 262144
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_tx_start,
   output logic [DATA_BITS-1:0]          o_tx_data,
   input  logic                          i_tx_done_tick,
   output logic                          o_busy,
   output logic [clog2(NUM_REQ)-1:0]     o_grant_id,
   output logic                          o_timeout
);

   localparam int             IW      = clog2(NUM_REQ);
   localparam int             CW      = clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0]  WD_MAX  = '1;

   sched_state_t         state;
   logic [CW-1:0]        wd_cnt;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 arb_any;
   logic [DATA_BITS-1:0] win_byte;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req  (i_req_valid),
      .last (o_grant_id),
      .gnt  (arb_gnt),
      .idx  (arb_idx),
      .any  (arb_any)
   );

   assign win_byte    = i_req_data[arb_idx*DATA_BITS +: DATA_BITS];
   // Accept is the only combinational output: the handshake completes in the arbitration cycle.
   assign o_req_ready = (state == S_IDLE) ? arb_gnt : '0;

`ifdef UART_SCHED_ID_EN
   logic [DATA_BITS-1:0] data_buf;
   logic                 id_phase;
   logic [DATA_BITS-1:0] id_byte;
   assign id_byte = DATA_BITS'(SCHED_ID_BASE) + DATA_BITS'(arb_idx);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         o_tx_start <= 1'b0;
         o_tx_data  <= '0;
         o_busy     <= 1'b0;
         o_timeout  <= 1'b0;
         o_grant_id <= IW'(NUM_REQ - 1);
         wd_cnt     <= '0;
`ifdef UART_SCHED_ID_EN
         data_buf   <= '0;
         id_phase   <= 1'b0;
`endif
      end else begin
         o_tx_start <= 1'b0;
         o_timeout  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (arb_any) begin
                  o_grant_id <= arb_idx;
                  o_tx_start <= 1'b1;
                  o_busy     <= 1'b1;
`ifdef UART_SCHED_ID_EN
                  data_buf   <= win_byte;
                  o_tx_data  <= id_byte;
                  id_phase   <= 1'b1;
                  state      <= S_ID;
`else
                  o_tx_data  <= win_byte;
                  state      <= S_ISSUE;
`endif
               end
            end
            // Start pulse is high during these states; arm the watchdog for the frame.
            S_ISSUE, S_ID: begin
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (i_tx_done_tick) begin
`ifdef UART_SCHED_ID_EN
                  if (id_phase) begin
                     id_phase   <= 1'b0;
                     o_tx_data  <= data_buf;
                     o_tx_start <= 1'b1;
                     state      <= S_ISSUE;
                  end else begin
                     o_busy <= 1'b0;
                     state  <= S_IDLE;
                  end
`else
                  o_busy <= 1'b0;
                  state  <= S_IDLE;
`endif
               end else if (wd_cnt == WD_LAST) begin
                  o_timeout <= 1'b1;
                  o_busy    <= 1'b0;
                  state     <= S_IDLE;
`ifdef UART_SCHED_ID_EN
                  id_phase  <= 1'b0;
`endif
               end else if (wd_cnt != WD_MAX) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a frame scoreboard; honours UART_SCHED_ID_EN.
module tb_uart_tx_sched;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    valid = '0;
   logic [N*DB-1:0] rdata = '0;
   logic            done = 1'b0;
   logic [N-1:0]    ready;
   logic            start;
   logic [DB-1:0]   txd;
   logic            busy;
   logic [1:0]      gid;
   logic            timeout;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   uart_tx_sched #(.NUM_REQ(N), .DATA_BITS(DB), .TIMEOUT_CYC(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req_valid    (valid),
      .i_req_data     (rdata),
      .o_req_ready    (ready),
      .o_tx_start     (start),
      .o_tx_data      (txd),
      .i_tx_done_tick (done),
      .o_busy         (busy),
      .o_grant_id     (gid),
      .o_timeout      (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"},   32'(ready),   32'h0);
      chk({tag, "_start"},   32'(start),   32'h0);
      chk({tag, "_data"},    32'(txd),     32'h0);
      chk({tag, "_busy"},    32'(busy),    32'h0);
      chk({tag, "_timeout"}, 32'(timeout), 32'h0);
      chk({tag, "_gid"},     32'(gid),     32'h3);
   endtask

   task automatic set_req(input int k, input logic [7:0] d);
      rdata[k*DB +: DB] = d;
      valid[k] = 1'b1;
   endtask

   // Expected frames for one grant: optional ID byte, then the data byte.
   task automatic push(input int k, input logic [7:0] d, input bit data_too);
`ifdef UART_SCHED_ID_EN
      sb.push_back('{id: 2'(k), data: 8'hA0 + 8'(k)});
      if (data_too) sb.push_back('{id: 2'(k), data: d});
`else
      if (data_too || !data_too) sb.push_back('{id: 2'(k), data: d});
`endif
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      chk({tag, "_start"}, 32'(start), 32'h1);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s_sb: observed start with empty scoreboard, expected none", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_txdata"}, 32'(txd), 32'(e.data));
         chk({tag, "_gid"},    32'(gid), 32'(e.id));
      end
   endtask

   task automatic do_done();
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic take_frame(input string tag);
      pop_chk(tag);
      repeat (3) @(negedge clk);
      do_done();
   endtask

   task automatic grant(input int k, input logic [7:0] d, input bit drop, input string tag);
      #1;
      chk({tag, "_ready"}, 32'(ready), 32'(1) << k);
      push(k, d, 1'b1);
      @(negedge clk);
      if (drop) valid[k] = 1'b0;
      take_frame(tag);
`ifdef UART_SCHED_ID_EN
      take_frame({tag, "_d"});
`endif
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // stray done tick in idle
      do_done();
      chk("stray_busy",  32'(busy),  32'h0);
      chk("stray_start", 32'(start), 32'h0);

      set_req(2, 8'h5A);
      grant(2, 8'h5A, 1'b1, "single");
      chk("single_busy_after", 32'(busy), 32'h0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2_gid", 32'(gid), 32'h3);

      // all four held: order 0,1,2,3,0, each start 2 cycles after previous done
      for (int k = 0; k < N; k++) set_req(k, 8'h10 + 8'(k));
      for (int i = 0; i < 5; i++) grant(i % N, 8'h10 + 8'(i % N), 1'b0, $sformatf("rr%0d", i));
      valid = '0;

      set_req(3, 8'hC3);
      grant(3, 8'hC3, 1'b1, "part3");
      set_req(1, 8'h91);
      set_req(3, 8'hC4);
      grant(1, 8'h91, 1'b1, "part1");
      grant(3, 8'hC4, 1'b1, "part3b");

      // watchdog: no done tick; an ID-frame timeout abandons the data byte
      set_req(0, 8'h77);
      #1;
      chk("wd_ready", 32'(ready), 32'h1);
      push(0, 8'h77, 1'b0);
      @(negedge clk);
      valid[0] = 1'b0;
      pop_chk("wd");
      cyc = 0;
      while (!timeout && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("wd_cycles", 32'(cyc), 32'(TO + 1));
      chk("wd_busy",   32'(busy),  32'h0);
      chk("wd_start",  32'(start), 32'h0);
      @(negedge clk);
      chk("wd_pulse_len", 32'(timeout), 32'h0);
      set_req(2, 8'hE2);
      grant(2, 8'hE2, 1'b1, "wd_next");

      // done tick on the terminal-count cycle wins
      set_req(1, 8'h44);
      #1;
      chk("tie_ready", 32'(ready), 32'h2);
      push(1, 8'h44, 1'b1);
      @(negedge clk);
      valid[1] = 1'b0;
      pop_chk("tie");
      repeat (TO) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("tie_timeout", 32'(timeout), 32'h0);
`ifdef UART_SCHED_ID_EN
      take_frame("tie_d");
`endif
      chk("tie_busy", 32'(busy), 32'h0);

      // reset in the middle of a frame
      set_req(1, 8'h33);
      #1;
      chk("mid_ready", 32'(ready), 32'h2);
      push(1, 8'h33, 1'b1);
      @(negedge clk);
      valid[1] = 1'b0;
      pop_chk("mid");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_busy_after", 32'(busy), 32'h0);

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
